// File: rtl/axi4_small_mem_slave.sv
// rtl/axi4_small_mem_slave.sv - AXI4 single-transaction memory slave with byte-writable word RAM
module axi4_small_mem_slave #(
  parameter int A     = 32,
  parameter int D     = 64,
  parameter int ID    = 8,
  parameter int DEPTH = 1024
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ar_valid,
  output logic          o_ar_ready,
  input  logic [A-1:0]  i_ar_addr,
  input  logic [7:0]    i_ar_len,
  input  logic [ID-1:0] i_ar_id,
  output logic          o_r_valid,
  input  logic          i_r_ready,
  output logic [D-1:0]  o_r_data,
  output logic [1:0]    o_r_resp,
  output logic          o_r_last,
  output logic [ID-1:0] o_r_id,
  input  logic          i_aw_valid,
  output logic          o_aw_ready,
  input  logic [A-1:0]  i_aw_addr,
  input  logic [7:0]    i_aw_len,
  input  logic [ID-1:0] i_aw_id,
  input  logic          i_w_valid,
  output logic          o_w_ready,
  input  logic [D-1:0]  i_w_data,
  input  logic [7:0]    i_w_strb,
  input  logic          i_w_last,
  output logic          o_b_valid,
  input  logic          i_b_ready,
  output logic [1:0]    o_b_resp,
  output logic [ID-1:0] o_b_id
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WD, S_WB} state_t;

  state_t r_state, w_next;

  logic r_prio_wr;

  logic [D-1:0] r_mem [DEPTH];

  logic [7:0]    r_rd_len, r_rd_cnt;
  logic [IW-1:0] r_rd_idx;
  logic          r_rd_oor;
  logic [D-1:0]  r_r_data;
  logic [1:0]    r_r_resp;
  logic          r_r_last;
  logic [ID-1:0] r_r_id;

  logic [7:0]    r_wr_len, r_wr_cnt;
  logic [IW-1:0] r_wr_idx;
  logic          r_wr_oor;
  logic          r_wr_err;
  logic [1:0]    r_b_resp;
  logic [ID-1:0] r_b_id;

  logic          w_ar_hs, w_aw_hs, w_r_hs, w_w_hs;
  logic [IW-1:0] w_ar_idx, w_aw_idx, w_rd_idx;
  logic          w_ar_oor, w_aw_oor;
  logic [D-1:0]  w_rd_word;
  logic          w_w_final, w_err_next;
  logic          w_unused;

  // Burst start index and out-of-range test: any address bit above the word index is set
  assign w_ar_idx   = i_ar_addr[3 +: IW];
  assign w_aw_idx   = i_aw_addr[3 +: IW];
  assign w_ar_oor   = |i_ar_addr[A-1:IW+3];
  assign w_aw_oor   = |i_aw_addr[A-1:IW+3];
  assign w_unused   = &{1'b0, i_ar_addr[2:0], i_aw_addr[2:0]};

  assign w_ar_hs    = o_ar_ready;
  assign w_aw_hs    = o_aw_ready;
  assign w_r_hs     = o_r_valid && i_r_ready;
  assign w_w_hs     = o_w_ready && i_w_valid;
  assign w_w_final  = (r_wr_cnt == r_wr_len);
  assign w_err_next = r_wr_err | (i_w_last != w_w_final);

  // In IDLE the first beat is fetched straight from the incoming AR address
  assign w_rd_idx   = (r_state == S_IDLE) ? w_ar_idx : r_rd_idx;
  assign w_rd_word  = r_mem[w_rd_idx];

  assign o_r_data   = r_r_data;
  assign o_r_resp   = r_r_resp;
  assign o_r_last   = r_r_last;
  assign o_r_id     = r_r_id;
  assign o_b_resp   = r_b_resp;
  assign o_b_id     = r_b_id;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_ar_hs) w_next = S_RD;
              else if (w_aw_hs) w_next = S_WD;
      S_RD:   if (w_r_hs && r_r_last) w_next = S_IDLE;
      S_WD:   if (w_w_hs && w_w_final) w_next = S_WB;
      S_WB:   if (i_b_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Channel valids follow the state; address readies arbitrate combinationally in IDLE
  always_comb begin
    o_r_valid  = (r_state == S_RD);
    o_w_ready  = (r_state == S_WD);
    o_b_valid  = (r_state == S_WB);
    o_ar_ready = 1'b0;
    o_aw_ready = 1'b0;
    if (r_state == S_IDLE && !i_rst) begin
      o_ar_ready = i_ar_valid && (!i_aw_valid || !r_prio_wr);
      o_aw_ready = i_aw_valid && (!i_ar_valid || r_prio_wr);
    end
  end

  // Fairness: priority flips after every accepted address
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                   r_prio_wr <= 1'b1;
    else if (w_ar_hs || w_aw_hs) r_prio_wr <= ~r_prio_wr;
  end

  // Read beat pipeline: load the next beat on AR accept or on each non-final R handshake
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_len <= '0;
      r_rd_cnt <= '0;
      r_rd_idx <= '0;
      r_rd_oor <= 1'b0;
      r_r_data <= '0;
      r_r_resp <= 2'b00;
      r_r_last <= 1'b0;
      r_r_id   <= '0;
    end else if (w_ar_hs) begin
      r_rd_len <= i_ar_len;
      r_rd_cnt <= '0;
      r_rd_idx <= w_ar_idx + IW'(1);
      r_rd_oor <= w_ar_oor;
      r_r_data <= w_ar_oor ? '0 : w_rd_word;
      r_r_resp <= w_ar_oor ? 2'b11 : 2'b00;
      r_r_last <= (i_ar_len == 8'd0);
      r_r_id   <= i_ar_id;
    end else if (w_r_hs && !r_r_last) begin
      r_rd_cnt <= r_rd_cnt + 8'd1;
      r_rd_idx <= r_rd_idx + IW'(1);
      r_r_data <= r_rd_oor ? '0 : w_rd_word;
      r_r_last <= (r_rd_cnt + 8'd1 == r_rd_len);
    end
  end

  // Write burst tracking and response generation
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_len <= '0;
      r_wr_cnt <= '0;
      r_wr_idx <= '0;
      r_wr_oor <= 1'b0;
      r_wr_err <= 1'b0;
      r_b_resp <= 2'b00;
      r_b_id   <= '0;
    end else if (w_aw_hs) begin
      r_wr_len <= i_aw_len;
      r_wr_cnt <= '0;
      r_wr_idx <= w_aw_idx;
      r_wr_oor <= w_aw_oor;
      r_wr_err <= 1'b0;
      r_b_id   <= i_aw_id;
    end else if (w_w_hs) begin
      r_wr_cnt <= r_wr_cnt + 8'd1;
      r_wr_idx <= r_wr_idx + IW'(1);
      r_wr_err <= w_err_next;
      if (w_w_final) r_b_resp <= r_wr_oor ? 2'b11 : (w_err_next ? 2'b10 : 2'b00);
    end
  end

  // Byte-lane memory write; contents survive reset
  always_ff @(posedge i_clk) begin
    if (w_w_hs && !r_wr_oor) begin
      for (int i = 0; i < D/8; i++) begin
        if (i_w_strb[i]) r_mem[r_wr_idx][i*8 +: 8] <= i_w_data[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4_small_mem_slave.sv
// tb/tb_axi4_small_mem_slave.sv - directed self-checking bench for axi4_small_mem_slave
module tb_axi4_small_mem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ar_valid = 1'b0, ar_ready;
  logic [31:0] ar_addr = '0;
  logic [7:0]  ar_len = '0, ar_id = '0;
  logic        r_valid, r_ready = 1'b0, r_last;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic [7:0]  r_id;
  logic        aw_valid = 1'b0, aw_ready;
  logic [31:0] aw_addr = '0;
  logic [7:0]  aw_len = '0, aw_id = '0;
  logic        w_valid = 1'b0, w_ready, w_last = 1'b0;
  logic [63:0] w_data = '0;
  logic [7:0]  w_strb = '0;
  logic        b_valid, b_ready = 1'b0;
  logic [1:0]  b_resp;
  logic [7:0]  b_id;

  int n_chk = 0;
  int n_pass = 0;

  logic [63:0] wr_data [0:7];
  logic [7:0]  wr_strb [0:7];
  logic        wr_last [0:7];
  logic [63:0] rd_data [0:15];
  logic [1:0]  rd_resp [0:15];
  logic        rd_last [0:15];
  logic [7:0]  rd_id   [0:15];
  int          rd_n, rd_cycles, rd_stall_bad, hs_wait;
  logic        rd_first, b_first;
  logic [1:0]  b_resp_seen;
  logic [7:0]  b_id_seen;
  logic        pat [0:3];

  always #5 clk = ~clk;

  axi4_small_mem_slave dut (
    .i_clk(clk), .i_rst(rst),
    .i_ar_valid(ar_valid), .o_ar_ready(ar_ready), .i_ar_addr(ar_addr), .i_ar_len(ar_len), .i_ar_id(ar_id),
    .o_r_valid(r_valid), .i_r_ready(r_ready), .o_r_data(r_data), .o_r_resp(r_resp), .o_r_last(r_last), .o_r_id(r_id),
    .i_aw_valid(aw_valid), .o_aw_ready(aw_ready), .i_aw_addr(aw_addr), .i_aw_len(aw_len), .i_aw_id(aw_id),
    .i_w_valid(w_valid), .o_w_ready(w_ready), .i_w_data(w_data), .i_w_strb(w_strb), .i_w_last(w_last),
    .o_b_valid(b_valid), .i_b_ready(b_ready), .o_b_resp(b_resp), .o_b_id(b_id)
  );

  // Tasks start and end 1ns after a rising edge; outputs are sampled 2ns after the edge.
  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] id);
    ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_id = id; #1;
    hs_wait = 0;
    while (!ar_ready && hs_wait < 20) begin @(posedge clk); #2; hs_wait++; end
    if (hs_wait == 20) begin n_chk++; $display("FAIL ar_timeout: ar_ready never seen"); end
    @(posedge clk); #1; ar_valid = 1'b0;
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] id);
    aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_id = id; #1;
    hs_wait = 0;
    while (!aw_ready && hs_wait < 20) begin @(posedge clk); #2; hs_wait++; end
    if (hs_wait == 20) begin n_chk++; $display("FAIL aw_timeout: aw_ready never seen"); end
    @(posedge clk); #1; aw_valid = 1'b0;
  endtask

  task automatic w_send(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      w_valid = 1'b1; w_data = wr_data[i]; w_strb = wr_strb[i]; w_last = wr_last[i]; #1;
      t = 0;
      while (!w_ready && t < 20) begin @(posedge clk); #2; t++; end
      if (t == 20) begin n_chk++; $display("FAIL w_timeout: w_ready never seen"); end
      @(posedge clk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
    b_ready = 1'b1; #1;
    b_first = b_valid;
    t = 0;
    while (!b_valid && t < 20) begin @(posedge clk); #2; t++; end
    if (t == 20) begin n_chk++; $display("FAIL b_timeout: b_valid never seen"); end
    b_resp_seen = b_resp; b_id_seen = b_id;
    @(posedge clk); #1; b_ready = 1'b0;
  endtask

  task automatic rd_collect(input int max_beats);
    logic        stalled;
    logic [74:0] prev;
    logic        done;
    int          k;
    rd_n = 0; rd_stall_bad = 0; stalled = 1'b0; prev = '0; done = 1'b0; k = 0;
    while (!done && k < 64) begin
      r_ready = pat[k % 4]; #1;
      if (k == 0) rd_first = r_valid;
      if (stalled && r_valid && ({r_data, r_resp, r_last, r_id} !== prev)) rd_stall_bad++;
      stalled = r_valid && !r_ready;
      prev = {r_data, r_resp, r_last, r_id};
      if (r_valid && r_ready && rd_n < 16) begin
        rd_data[rd_n] = r_data; rd_resp[rd_n] = r_resp; rd_last[rd_n] = r_last; rd_id[rd_n] = r_id;
        rd_n++;
      end
      @(posedge clk); #1;
      k++;
      if (rd_n > 0 && (rd_last[rd_n-1] || rd_n == max_beats)) done = 1'b1;
    end
    rd_cycles = k;
    r_ready = 1'b0;
    if (!done) begin n_chk++; $display("FAIL r_timeout: read burst did not finish"); end
  endtask

  task automatic set_pat(input logic p0, input logic p1, input logic p2, input logic p3);
    pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; ar_valid = 1'b1; aw_valid = 1'b1; #1;
    n_chk++; if (ar_ready !== 1'b0) $display("FAIL rst_ar_ready got %b want 0", ar_ready); else n_pass++;
    n_chk++; if (aw_ready !== 1'b0) $display("FAIL rst_aw_ready got %b want 0", aw_ready); else n_pass++;
    @(posedge clk); #1; ar_valid = 1'b0; aw_valid = 1'b0; rst = 1'b0; #1;
    n_chk++; if ({r_valid, b_valid, w_ready} !== 3'b000) $display("FAIL rst_valids got %b want 000", {r_valid, b_valid, w_ready}); else n_pass++;
    n_chk++; if ({r_data, r_resp, r_last, r_id} !== 75'd0) $display("FAIL rst_r_chan got %h want 0", {r_data, r_resp, r_last, r_id}); else n_pass++;
    n_chk++; if ({b_resp, b_id} !== 10'd0) $display("FAIL rst_b_chan got %h want 0", {b_resp, b_id}); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_arbitration;
    set_pat(1, 1, 1, 1);
    ar_valid = 1'b1; ar_addr = 32'h100; ar_len = 8'd0; ar_id = 8'h01;
    aw_valid = 1'b1; aw_addr = 32'h100; aw_len = 8'd0; aw_id = 8'h02; #1;
    n_chk++; if ({aw_ready, ar_ready} !== 2'b10) $display("FAIL arb_first got aw/ar=%b want 10", {aw_ready, ar_ready}); else n_pass++;
    @(posedge clk); #1; aw_valid = 1'b0;
    wr_data[0] = 64'hA5A5_0000_0000_005A; wr_strb[0] = 8'hFF; wr_last[0] = 1'b1;
    w_send(1);
    aw_valid = 1'b1; #1;
    n_chk++; if ({aw_ready, ar_ready} !== 2'b01) $display("FAIL arb_second got aw/ar=%b want 01", {aw_ready, ar_ready}); else n_pass++;
    @(posedge clk); #1; aw_valid = 1'b0; ar_valid = 1'b0;
    rd_collect(1);
    n_chk++; if (rd_data[0] !== 64'hA5A5_0000_0000_005A) $display("FAIL arb_read_data got %h want a5a500000000005a", rd_data[0]); else n_pass++;
    ar_valid = 1'b1; aw_valid = 1'b1; aw_addr = 32'h108; #1;
    n_chk++; if ({aw_ready, ar_ready} !== 2'b10) $display("FAIL arb_third got aw/ar=%b want 10", {aw_ready, ar_ready}); else n_pass++;
    @(posedge clk); #1; aw_valid = 1'b0; ar_valid = 1'b0;
    wr_data[0] = 64'h0; w_send(1);
  endtask

  task automatic test_write_read;
    aw_send(32'h40, 8'd3, 8'h05);
    wr_data[0] = 64'h11; wr_data[1] = 64'h22; wr_data[2] = 64'h33; wr_data[3] = 64'h44;
    for (int i = 0; i < 4; i++) begin wr_strb[i] = 8'hFF; wr_last[i] = (i == 3); end
    w_send(4);
    n_chk++; if (b_first !== 1'b1) $display("FAIL wr_b_latency got b_valid=%b want 1", b_first); else n_pass++;
    n_chk++; if ({b_resp_seen, b_id_seen} !== {2'b00, 8'h05}) $display("FAIL wr_b got resp/id=%h want 005", {b_resp_seen, b_id_seen}); else n_pass++;
    set_pat(1, 1, 1, 1);
    ar_send(32'h40, 8'd3, 8'h06);
    n_chk++; if (hs_wait !== 0) $display("FAIL ar_after_b got wait=%0d want 0", hs_wait); else n_pass++;
    rd_collect(4);
    n_chk++; if (rd_first !== 1'b1) $display("FAIL rd_latency got r_valid=%b want 1", rd_first); else n_pass++;
    n_chk++; if ({rd_data[0], rd_data[1], rd_data[2], rd_data[3]} !== {64'h11, 64'h22, 64'h33, 64'h44})
      $display("FAIL rd_data got %h %h %h %h want 11 22 33 44", rd_data[0], rd_data[1], rd_data[2], rd_data[3]); else n_pass++;
    n_chk++; if ({rd_last[3], rd_last[2], rd_last[1], rd_last[0]} !== 4'b1000)
      $display("FAIL rd_last got %b want 1000", {rd_last[3], rd_last[2], rd_last[1], rd_last[0]}); else n_pass++;
    n_chk++; if ({rd_id[0], rd_id[3], rd_resp[0], rd_resp[3]} !== {8'h06, 8'h06, 2'b00, 2'b00})
      $display("FAIL rd_id_resp got %h want 06060", {rd_id[0], rd_id[3], rd_resp[0], rd_resp[3]}); else n_pass++;
    n_chk++; if (rd_cycles !== 4) $display("FAIL rd_rate got %0d cycles want 4", rd_cycles); else n_pass++;
  endtask

  task automatic test_back_to_back;
    set_pat(1, 1, 1, 1);
    ar_send(32'h48, 8'd0, 8'h07);
    n_chk++; if (hs_wait !== 0) $display("FAIL b2b_ar got wait=%0d want 0", hs_wait); else n_pass++;
    rd_collect(1);
    n_chk++; if (rd_data[0] !== 64'h22) $display("FAIL b2b_data got %h want 22", rd_data[0]); else n_pass++;
    ar_send(32'h50, 8'd0, 8'h08);
    n_chk++; if (hs_wait !== 0) $display("FAIL b2b_ar2 got wait=%0d want 0", hs_wait); else n_pass++;
    rd_collect(1);
  endtask

  task automatic test_strobes;
    aw_send(32'h0, 8'd3, 8'h01);
    for (int i = 0; i < 4; i++) begin wr_data[i] = 64'hFFFF_FFFF_FFFF_FFFF; wr_strb[i] = 8'hFF; wr_last[i] = (i == 3); end
    w_send(4);
    aw_send(32'h0, 8'd0, 8'h02);
    wr_data[0] = 64'h0; wr_strb[0] = 8'h0F; wr_last[0] = 1'b1;
    w_send(1);
    set_pat(1, 0, 0, 1);
    ar_send(32'h0, 8'd3, 8'h03);
    rd_collect(4);
    n_chk++; if (rd_data[0] !== 64'hFFFF_FFFF_0000_0000) $display("FAIL strb_data got %h want ffffffff00000000", rd_data[0]); else n_pass++;
    n_chk++; if (rd_data[1] !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL strb_full got %h want ffffffffffffffff", rd_data[1]); else n_pass++;
    n_chk++; if (rd_stall_bad !== 0) $display("FAIL stall_stable got %0d changes want 0", rd_stall_bad); else n_pass++;
    n_chk++; if (rd_cycles !== 8 || rd_n !== 4) $display("FAIL stall_count got %0d cycles %0d beats want 8 4", rd_cycles, rd_n); else n_pass++;
  endtask

  task automatic test_errors;
    set_pat(1, 1, 1, 1);
    ar_send(32'h2000, 8'd1, 8'h09);
    rd_collect(2);
    n_chk++; if ({rd_resp[0], rd_resp[1]} !== 4'b1111) $display("FAIL decerr_resp got %b want 1111", {rd_resp[0], rd_resp[1]}); else n_pass++;
    n_chk++; if ({rd_data[0], rd_data[1]} !== 128'd0) $display("FAIL decerr_data got %h %h want 0", rd_data[0], rd_data[1]); else n_pass++;
    n_chk++; if ({rd_n[1:0], rd_last[1], rd_last[0]} !== 4'b1010) $display("FAIL decerr_last got n=%0d last=%b%b want 2 10", rd_n, rd_last[1], rd_last[0]); else n_pass++;
    aw_send(32'h80, 8'd2, 8'h0A);
    for (int i = 0; i < 3; i++) begin wr_data[i] = 64'h80 + 64'(i); wr_strb[i] = 8'hFF; wr_last[i] = (i == 1); end
    w_send(3);
    n_chk++; if ({b_resp_seen, b_id_seen} !== {2'b10, 8'h0A}) $display("FAIL slverr_b got resp/id=%h want 20a", {b_resp_seen, b_id_seen}); else n_pass++;
    aw_send(32'h2000, 8'd0, 8'h0B);
    wr_data[0] = 64'h1234; wr_strb[0] = 8'hFF; wr_last[0] = 1'b0;
    w_send(1);
    n_chk++; if (b_resp_seen !== 2'b11) $display("FAIL decerr_b got %b want 11", b_resp_seen); else n_pass++;
    ar_send(32'h0, 8'd0, 8'h0C);
    rd_collect(1);
    n_chk++; if (rd_data[0] !== 64'hFFFF_FFFF_0000_0000) $display("FAIL oor_nowrite got %h want ffffffff00000000", rd_data[0]); else n_pass++;
    ar_send(32'h88, 8'd0, 8'h0D);
    rd_collect(1);
    n_chk++; if (rd_data[0] !== 64'h81) $display("FAIL slverr_written got %h want 81", rd_data[0]); else n_pass++;
  endtask

  task automatic test_wrap;
    set_pat(1, 1, 1, 1);
    aw_send(32'h1FF8, 8'd1, 8'h01);
    wr_data[0] = 64'hDEAD_0000_0000_0001; wr_data[1] = 64'hBEEF_0000_0000_0002;
    wr_strb[0] = 8'hFF; wr_strb[1] = 8'hFF; wr_last[0] = 1'b0; wr_last[1] = 1'b1;
    w_send(2);
    n_chk++; if (b_resp_seen !== 2'b00) $display("FAIL wrap_b got %b want 00", b_resp_seen); else n_pass++;
    ar_send(32'h1FF8, 8'd1, 8'h02);
    rd_collect(2);
    n_chk++; if ({rd_data[0], rd_data[1]} !== {64'hDEAD_0000_0000_0001, 64'hBEEF_0000_0000_0002})
      $display("FAIL wrap_read got %h %h want dead...01 beef...02", rd_data[0], rd_data[1]); else n_pass++;
    n_chk++; if ({rd_resp[0], rd_resp[1]} !== 4'b0000) $display("FAIL wrap_resp got %b want 0000", {rd_resp[0], rd_resp[1]}); else n_pass++;
    ar_send(32'h0, 8'd0, 8'h03);
    rd_collect(1);
    n_chk++; if (rd_data[0] !== 64'hBEEF_0000_0000_0002) $display("FAIL wrap_word0 got %h want beef000000000002", rd_data[0]); else n_pass++;
  endtask

  task automatic test_reset_mid;
    r_ready = 1'b0;
    ar_send(32'h1FF8, 8'd3, 8'h03);
    #1;
    n_chk++; if (r_valid !== 1'b1) $display("FAIL mid_rvalid_before got %b want 1", r_valid); else n_pass++;
    rst = 1'b1; #1;
    n_chk++; if (r_valid !== 1'b0) $display("FAIL mid_rvalid_async got %b want 0", r_valid); else n_pass++;
    ar_valid = 1'b1; #1;
    n_chk++; if (ar_ready !== 1'b0) $display("FAIL mid_ar_ready_in_rst got %b want 0", ar_ready); else n_pass++;
    @(posedge clk); #1; ar_valid = 1'b0; rst = 1'b0;
    set_pat(1, 1, 1, 1);
    ar_send(32'h1FF8, 8'd0, 8'h04);
    n_chk++; if (hs_wait !== 0) $display("FAIL mid_fresh_ar got wait=%0d want 0", hs_wait); else n_pass++;
    rd_collect(1);
    n_chk++; if ({rd_data[0], rd_id[0], rd_last[0]} !== {64'hDEAD_0000_0000_0001, 8'h04, 1'b1})
      $display("FAIL mid_fresh_read got %h id %h last %b want dead000000000001 04 1", rd_data[0], rd_id[0], rd_last[0]); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_arbitration;
    test_write_read;
    test_back_to_back;
    test_strobes;
    test_errors;
    test_wrap;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/axi4_small_mem_slave.md
# axi4_small_mem_slave

AXI4 memory-mapped slave that terminates one `axi4_small_if` bus, the responder side of every channel, and backs it with an on-chip byte-writable word memory. It sits directly downstream of the NoC-side AXI master as the endpoint memory target. It accepts INCR bursts of up to 256 beats on read and write. It processes one transaction at a time, with fair arbitration between read and write requests.

## Interface
- `A`, 32: address width.
- `D`, 64: data width; must be 64 to match the 8-bit `w_strb`.
- `ID`, 8: transaction ID width.
- `DEPTH`, 1024: memory depth in D-bit words; power of two.
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `ar_valid`/`ar_ready`  in/out  1  AR handshake.
- `ar_addr` in A; `ar_len` in 8; `ar_id` in ID: read request (beats = `ar_len`+1).
- `r_valid` out 1; `r_ready` in 1; `r_data` out D; `r_resp` out 2; `r_last` out 1; `r_id` out ID: read data channel.
- `aw_valid`/`aw_ready`  in/out  1  AW handshake.
- `aw_addr` in A; `aw_len` in 8; `aw_id` in ID: write request.
- `w_valid`/`w_ready`  in/out  1  W handshake.
- `w_data` in D; `w_strb` in 8; `w_last` in 1: write data.
- `b_valid` out 1; `b_ready` in 1; `b_resp` out 2; `b_id` out ID: write response channel.

## Operation
- FSM states:
  - IDLE: the only state in which AR/AW are accepted.
  - RD: streams read beats.
  - WD: accepts write beats.
  - WB: holds the write response.
- Arbitration in IDLE:
  - `ar_ready` = IDLE && `ar_valid` && (!`aw_valid` || prio==RD).
  - `aw_ready` = IDLE && `aw_valid` && (!`ar_valid` || prio==WR).
  - `prio` resets to WR and toggles on every AR or AW handshake.
- Addressing:
  - Word index = `addr[3 +: log2(DEPTH)]`; `addr[2:0]` is ignored.
  - The index increments by 1 per beat and wraps modulo DEPTH.
  - Out-of-range: `addr >= DEPTH*8`, checked at burst start only.
- Read (RD):
  - Beat counter counts 0..`ar_len`; `r_id` = latched `ar_id`.
  - `r_resp` = 2'b00 normally. For an out-of-range burst, every beat returns `r_resp` = 2'b11 (DECERR) with `r_data` = 0.
  - `r_last` = 1 on beat `ar_len` only.
  - `r_data`/`r_resp`/`r_last`/`r_id` are held stable while `r_valid && !r_ready`.
  - Exit to IDLE on the handshake of the last beat.
- Write (WD):
  - `w_ready` = 1 throughout WD.
  - Each W handshake writes byte lanes where `w_strb[i]`=1; no write occurs for an out-of-range burst.
  - The burst always ends on handshake number `aw_len`+1. `w_last` is not used to terminate.
  - Error flag is set if `w_last` is 1 on any non-final beat or 0 on the final beat.
- Response (WB):
  - `b_id` = latched `aw_id`.
  - `b_resp` = 2'b11 if out of range, else 2'b10 if the `w_last` error flag is set, else 2'b00. DECERR has priority.
  - `b_valid` is held until `b_ready`, then the FSM returns to IDLE.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values:
  - FSM = IDLE, `prio` = WR.
  - `r_valid`, `b_valid`, `w_ready` = 0.
  - `r_data`, `r_resp`, `r_last`, `r_id`, `b_resp`, `b_id` = 0.
  - `ar_ready` and `aw_ready` are 0 while `rst` is high.
- Reset mid-burst: return to IDLE immediately and drop the transaction. Memory writes already performed are retained.
- Read:
  - AR handshake at cycle T gives first `r_valid` at T+1 (registered synchronous memory read).
  - With `r_ready` held high, one beat per cycle; the last beat is at T+1+`ar_len`.
  - Next AR/AW can be accepted at the cycle after the last R handshake.
- Write:
  - AW handshake at T gives `w_ready`=1 from T+1.
  - A beat written at cycle C is readable by a read whose AR is accepted after C.
  - `b_valid` at the cycle after the last W handshake.
  - Next AR/AW can be accepted at the cycle after the B handshake.
- A `ar_len`=255 burst at address index DEPTH-1 wraps to index 0 with no error.
- There are no combinational paths from `r_ready`, `w_valid` or `b_ready` to any output.
- `ar_ready` and `aw_ready` are combinational from `ar_valid` and `aw_valid` in IDLE.

## Test plan
- Write then read:
  - Stimulus: AW addr 0x40, len 3, id 0x5, data 0x11..0x44 with full strb; then AR addr 0x40, len 3, id 0x6.
  - Response: B resp 00 id 0x5; R beats 0x11,0x22,0x33,0x44 with id 0x6, `r_last` only on beat 3, first `r_valid` 1 cycle after AR.
- Strobes and backpressure:
  - Stimulus: write 0xFFFF_FFFF_FFFF_FFFF to 0x0; write 0x0 with strb 0x0F; then read with `r_ready` toggling 1,0,0,1.
  - Response: reads 0xFFFF_FFFF_0000_0000; `r_data` stable during stalls.
- Arbitration:
  - Stimulus: `ar_valid` and `aw_valid` asserted in the same cycle, twice in succession after reset.
  - Response: write is accepted first, then read, then write again.
- Errors:
  - Stimulus: AR addr 0x2000 (= DEPTH*8), len 1; AW len 2 with `w_last` asserted on beat 1.
  - Response: two R beats with resp 11 and data 0; B resp 10.
- Wrap and reset:
  - Stimulus: read at addr (DEPTH-1)*8, len 1.
  - Response: beats come from words DEPTH-1 then 0.
  - Stimulus: assert `rst` mid-read-burst.
  - Response: `r_valid` low in the same cycle; a fresh AR is accepted after release.
